// File: rtl/y86_pkg.sv
// y86_pkg: shared icode, condition and CC constants for the condition-code unit.
package y86_pkg;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICMOVXX = 4'h2;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'h0,
        C_LE     = 4'h1,
        C_L      = 4'h2,
        C_E      = 4'h3,
        C_NE     = 4'h4,
        C_GE     = 4'h5,
        C_G      = 4'h6
    } cond_t;

    localparam int ZF_B = 0;
    localparam int SF_B = 1;
    localparam int OF_B = 2;

    localparam logic [2:0] CC_RST = 3'b001;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition decode against a CC snapshot.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       bad_ifun
);
    logic zf;
    logic lt;

    assign zf = cc[ZF_B];
    assign lt = cc[SF_B] ^ cc[OF_B];

    always_comb begin
        bad_ifun = ifun > C_G;
        cnd = ifun == C_ALWAYS ? 1'b1 :
              ifun == C_LE     ? lt | zf :
              ifun == C_L      ? lt :
              ifun == C_E      ? zf :
              ifun == C_NE     ? !zf :
              ifun == C_GE     ? !lt :
              ifun == C_G      ? !lt & !zf : 1'b0;
    end
endmodule

// File: rtl/cond_code_unit.sv
// cond_code_unit: execute-stage CC register and registered branch/cmov condition.
module cond_code_unit
    import y86_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    input  logic [2:0] alu_cc,
    input  logic       stat_ok,
    input  logic       stall,
    input  logic       bubble,
    output logic [2:0] cc_out,
    output logic       cnd,
    output logic       cnd_valid,
    output logic       cc_err
);
    logic acc;
    logic is_cond;
    logic eval_cnd;
    logic bad_ifun;

    assign acc     = valid_in & !stall & !bubble;
    assign is_cond = icode == IJXX || icode == ICMOVXX;

    // Evaluated against the pre-edge CC, so a jXX right after OPq sees the flags OPq wrote.
    cond_eval u_eval (
        .cc       (cc_out),
        .ifun     (ifun),
        .cnd      (eval_cnd),
        .bad_ifun (bad_ifun)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_out    <= CC_RST;
            cnd       <= 1'b0;
            cnd_valid <= 1'b0;
            cc_err    <= 1'b0;
        end else if (!stall) begin
            if (acc && icode == IOPQ && stat_ok) cc_out <= alu_cc;
            if (acc && is_cond) cnd <= eval_cnd & !bad_ifun;
            cnd_valid <= acc & is_cond;
            cc_err    <= acc & is_cond & bad_ifun;
        end
    end
endmodule

// File: tb/tb_cond_code_unit.sv
// tb_cond_code_unit: directed vectors with a scoreboard queue checked by a cnd_valid monitor.
module tb_cond_code_unit;
    logic       clk = 1'b0;
    logic       rst, valid_in, stat_ok, stall, bubble;
    logic [3:0] icode, ifun;
    logic [2:0] alu_cc;
    logic [2:0] cc_out;
    logic       cnd, cnd_valid, cc_err;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb[$];
    logic held = 1'b0;

    cond_code_unit dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .icode     (icode),
        .ifun      (ifun),
        .alu_cc    (alu_cc),
        .stat_ok   (stat_ok),
        .stall     (stall),
        .bubble    (bubble),
        .cc_out    (cc_out),
        .cnd       (cnd),
        .cnd_valid (cnd_valid),
        .cc_err    (cc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // A stalled edge keeps the previous pulse alive; it is not a new result.
    always @(posedge clk) held <= stall && !rst;

    always @(negedge clk) begin
        if (cnd_valid && !held) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cnd_valid: got cnd=%b cc_err=%b expected none", cnd, cc_err);
            end else begin
                chk("scoreboard_cnd_err", {1'b0, cnd, cc_err}, {1'b0, sb.pop_front()});
            end
        end else if (!cnd_valid) begin
            chk("cc_err_idle", {2'b0, cc_err}, 3'b0);
        end
    end

    task automatic drive(input logic r, input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [2:0] a, input logic ok, input logic st, input logic bb,
                         input logic push, input logic [1:0] exp);
        rst = r; valid_in = v; icode = ic; ifun = fn; alu_cc = a; stat_ok = ok; stall = st; bubble = bb;
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 4'h0, 3'b000, 1, 0, 0, 0, 2'b00);
    endtask

    task automatic jxx(input logic [3:0] fn, input logic [1:0] exp);
        drive(0, 1, 4'h7, fn, 3'b000, 1, 0, 0, 1, exp);
    endtask

    task automatic opq(input logic [2:0] a, input logic ok);
        drive(0, 1, 4'h6, 4'h0, a, ok, 0, 0, 0, 2'b00);
    endtask

    initial begin
        drive(1, 1, 4'h7, 4'h0, 3'b111, 1, 1, 1, 0, 2'b00);
        drive(1, 0, 4'h0, 4'h0, 3'b000, 1, 0, 0, 0, 2'b00);
        chk("reset_cc", cc_out, 3'b001);
        chk("reset_flags", {cnd, cnd_valid, cc_err}, 3'b000);

        jxx(4'h3, 2'b10);
        chk("cc_after_e", cc_out, 3'b001);
        opq(3'b110, 1);
        chk("cc_opq_write", cc_out, 3'b110);
        jxx(4'h2, 2'b00);
        jxx(4'h6, 2'b10);
        chk("cc_hold_on_jxx", cc_out, 3'b110);

        drive(1, 1, 4'h7, 4'h0, 3'b000, 1, 0, 0, 0, 2'b00);
        chk("midstream_reset_valid", {2'b0, cnd_valid}, 3'b000);
        chk("midstream_reset_cc", cc_out, 3'b001);

        opq(3'b010, 0);
        chk("cc_stat_blocked", cc_out, 3'b001);
        jxx(4'h4, 2'b00);

        drive(0, 1, 4'h2, 4'h9, 3'b000, 1, 0, 0, 1, 2'b01);
        chk("cmov_bad_pulse", {cnd, cnd_valid, cc_err}, 3'b011);
        idle();
        chk("cmov_bad_one_cycle", {1'b0, cnd_valid, cc_err}, 3'b000);

        jxx(4'h0, 2'b10);
        drive(0, 1, 4'h6, 4'h0, 3'b010, 1, 1, 0, 0, 2'b00);
        chk("stall1_cc", cc_out, 3'b001);
        chk("stall1_frozen", {cnd, cnd_valid, cc_err}, 3'b110);
        drive(0, 1, 4'h7, 4'h9, 3'b010, 1, 1, 1, 0, 2'b00);
        chk("stall2_cc", cc_out, 3'b001);
        chk("stall2_frozen", {cnd, cnd_valid, cc_err}, 3'b110);
        drive(0, 1, 4'h6, 4'h0, 3'b010, 1, 0, 1, 0, 2'b00);
        chk("bubble_cc", cc_out, 3'b001);
        chk("bubble_valid", {1'b0, cnd_valid, cc_err}, 3'b000);

        jxx(4'h5, 2'b10);
        jxx(4'h1, 2'b10);
        jxx(4'h7, 2'b01);
        drive(0, 0, 4'h7, 4'h0, 3'b000, 1, 0, 0, 0, 2'b00);
        chk("invalid_no_pulse", {1'b0, cnd_valid, cc_err}, 3'b000);
        chk("invalid_cnd_hold", {2'b0, cnd}, 3'b000);

        opq(3'b010, 1);
        jxx(4'h2, 2'b10);
        chk("cc_sf_only", cc_out, 3'b010);
        jxx(4'h5, 2'b00);
        jxx(4'h3, 2'b00);
        opq(3'b101, 1);
        jxx(4'h6, 2'b00);
        jxx(4'h1, 2'b10);
        drive(0, 1, 4'h2, 4'h4, 3'b000, 1, 0, 0, 1, 2'b00);
        drive(0, 1, 4'h2, 4'hf, 3'b000, 1, 0, 0, 1, 2'b01);
        idle();
        idle();
        idle();
        chk("scoreboard_drained", 3'(sb.size()), 3'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cond_code_unit.md
COND_CODE_UNIT -- requirements
Module: cond_code_unit

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width and meaning.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 valid_in  input  1  execute-stage instruction is valid this cycle.
REQ-005 icode  input  4  instruction code.
REQ-006 ifun  input  4  function or condition code.
REQ-007 alu_cc  input  3  flags from the 64-bit adder: bit0=ZF, bit1=SF, bit2=OF.
REQ-008 stat_ok  input  1  downstream status is AOK; 0 blocks the CC write.
REQ-009 stall  input  1  hold all state this cycle.
REQ-010 bubble  input  1  squash the current instruction; no CC write and no cnd_valid.
REQ-011 cc_out  output  3  current CC register value, in the same bit order as alu_cc.
REQ-012 cnd  output  1  registered condition result.
REQ-013 cnd_valid  output  1  one-cycle pulse; cnd is meaningful.
REQ-014 cc_err  output  1  one-cycle pulse; jXX or cmovXX arrived with ifun > 6.

Function
REQ-015 Let acc = valid_in & !stall & !bubble.
REQ-016 The CC register SHALL load alu_cc on the rising edge when acc & icode==OPq(4'h6) & stat_ok; otherwise it holds.
REQ-017 A CC write SHALL be visible on cc_out one cycle after the edge that loads it.
REQ-018 Condition evaluation SHALL use the pre-edge cc_out value.
REQ-019 Conditions SHALL be: ifun0 always=1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=!ZF; 5 ge=!(SF^OF); 6 g=!(SF^OF)&!ZF.
REQ-020 When acc & icode is jXX(4'h7) or cmovXX(4'h2), the edge SHALL register cnd = condition(ifun) and set cnd_valid=1.
REQ-021 For those icodes with ifun > 6, the edge SHALL register cnd=0, cnd_valid=1 and cc_err=1.
REQ-022 For all other icodes, or when !acc, the edge SHALL register cnd_valid=0 and cc_err=0; cnd holds its value.
REQ-023 When stall=1, every register (CC, cnd, cnd_valid, cc_err) SHALL hold its value.
REQ-024 Stall SHALL take priority over bubble.
REQ-025 When bubble=1 and stall=0, the edge SHALL clear cnd_valid and cc_err, and the CC register holds.
REQ-026 A jXX that directly follows an OPq SHALL evaluate against the flags that OPq wrote, with no bypass path required.
REQ-027 Latency from an accepted jXX/cmovXX to cnd_valid SHALL be exactly 1 cycle.
REQ-028 Throughput SHALL be 1 instruction per cycle.

Reset
REQ-029 On a rising edge with rst=1, the block SHALL set cc_out=3'b001 (ZF=1, SF=0, OF=0), cnd=0, cnd_valid=0 and cc_err=0.
REQ-030 Reset SHALL override stall, bubble and every other input.
REQ-031 A reset asserted mid-stream SHALL discard any in-flight cnd.

Structure
REQ-032 Package y86_pkg SHALL hold: icode constants IOPQ, IJXX and ICMOVXX; condition encodings C_ALWAYS..C_G; CC bit indices ZF_B=0, SF_B=1, OF_B=2; and the CC reset value.
REQ-033 Combinational sub-module cond_eval SHALL take cc[2:0] and ifun[3:0] and produce cnd and bad_ifun.
REQ-034 The registers SHALL stay in cond_code_unit.

Verification
REQ-035 Reset, then jXX with ifun=3 (e) -> next cycle cnd=1, cnd_valid=1; cc_out=001.
REQ-036 OPq with alu_cc=3'b110 and stat_ok=1, then jXX with ifun=2 (l) -> cc_out=110 and cnd=0 (SF^OF=0); jXX with ifun=6 (g) -> cnd=1.
REQ-037 OPq with alu_cc=3'b010 and stat_ok=0 -> cc_out unchanged (001); a following jXX with ifun=4 (ne) -> cnd=0.
REQ-038 cmovXX with ifun=4'h9 -> cnd=0, cnd_valid=1 and cc_err=1 for exactly one cycle.
REQ-039 OPq with alu_cc=3'b010 and stall=1 for 2 cycles -> no CC change and all outputs frozen; with bubble=1 -> cnd_valid=0 and cc_out unchanged.
REQ-040 rst asserted while cnd_valid=1 -> next cycle cnd_valid=0 and cc_out=001.
